// File: rtl/refresh_sequencer.sv
// Refresh sequencer: turns timer refresh requests into a drain, PREA, REF
// command sequence and restarts the refresh interval when it is done.
module refresh_sequencer #(
    parameter int tRP   = 4,
    parameter int tRFC  = 10,
    parameter int BANKS = 16,
    parameter int CNTW  = 16
) (
    input  logic             CK_t,
    input  logic             reset,
    input  logic             refresh_almost,
    input  logic             refresh_rdy,
    input  logic [BANKS-1:0] bank_open,
    input  logic             cmd_busy,
    input  logic             cmd_gnt,
    output logic             hold_off,
    output logic             cmd_req,
    output logic [1:0]       cmd_code,
    output logic             refresh_busy,
    output logic             clear_refresh,
    output logic [CNTW-1:0]  ref_count
);

    localparam int MAXD = (tRP > tRFC) ? tRP : tRFC;
    localparam int CW   = $clog2(MAXD + 1);
    localparam logic [CW-1:0] RP_LD  = CW'(tRP - 1);
    localparam logic [CW-1:0] RFC_LD = CW'(tRFC - 1);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        PREA,
        WAIT_RP,
        REF,
        WAIT_RFC,
        CLEAR
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            hold_q, hold_d;
    logic [CNTW-1:0] count_q, count_d;

    always_ff @(posedge CK_t) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hold_d        = hold_q;
        count_d       = count_q;
        cmd_req       = 1'b0;
        cmd_code      = 2'b00;
        clear_refresh = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (refresh_almost || refresh_rdy) hold_d = 1'b1;
                if (refresh_rdy) state_d = DRAIN;
            end
            DRAIN: begin
                if (!cmd_busy) state_d = (|bank_open) ? PREA : REF;
            end
            PREA: begin
                cmd_req  = 1'b1;
                cmd_code = 2'b01;
                if (cmd_gnt) begin
                    cnt_d   = RP_LD;
                    state_d = WAIT_RP;
                end
            end
            WAIT_RP: begin
                if (cnt_q == '0) state_d = REF;
                else cnt_d = cnt_q - CW'(1);
            end
            REF: begin
                cmd_req  = 1'b1;
                cmd_code = 2'b10;
                if (cmd_gnt) begin
                    cnt_d   = RFC_LD;
                    state_d = WAIT_RFC;
                end
            end
            WAIT_RFC: begin
                if (cnt_q == '0) state_d = CLEAR;
                else cnt_d = cnt_q - CW'(1);
            end
            CLEAR: begin
                clear_refresh = 1'b1;
                count_d       = count_q + CNTW'(1);
                hold_d        = 1'b0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign hold_off     = hold_q;
    assign ref_count    = count_q;
    assign refresh_busy = (state_q != IDLE);

endmodule

// File: tb/tb_refresh_sequencer.sv
// Bench for refresh_sequencer: expected waveforms come from event times
// computed arithmetically per sequence, for a 16-bit and a 2-bit counter.
module tb_refresh_sequencer;

    localparam int TRP  = 4;
    localparam int TRFC = 10;

    logic        CK_t = 1'b0;
    logic        reset = 1'b1;
    logic        refresh_almost = 1'b0;
    logic        refresh_rdy = 1'b0;
    logic [15:0] bank_open = '0;
    logic        cmd_busy = 1'b0;
    logic        cmd_gnt = 1'b0;

    logic        hold_off, cmd_req, refresh_busy, clear_refresh;
    logic [1:0]  cmd_code;
    logic [15:0] ref_count;
    logic        hold_off2, cmd_req2, refresh_busy2, clear_refresh2;
    logic [1:0]  cmd_code2;
    logic [1:0]  ref_count2;

    logic [5:0] outs, outs2;
    assign outs  = {hold_off, cmd_req, cmd_code, refresh_busy, clear_refresh};
    assign outs2 = {hold_off2, cmd_req2, cmd_code2, refresh_busy2, clear_refresh2};

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n = 0;

    refresh_sequencer #(.tRP(TRP), .tRFC(TRFC), .BANKS(16), .CNTW(16)) dut (
        .CK_t(CK_t), .reset(reset),
        .refresh_almost(refresh_almost), .refresh_rdy(refresh_rdy),
        .bank_open(bank_open), .cmd_busy(cmd_busy), .cmd_gnt(cmd_gnt),
        .hold_off(hold_off), .cmd_req(cmd_req), .cmd_code(cmd_code),
        .refresh_busy(refresh_busy), .clear_refresh(clear_refresh),
        .ref_count(ref_count)
    );

    refresh_sequencer #(.tRP(TRP), .tRFC(TRFC), .BANKS(16), .CNTW(2)) dut2 (
        .CK_t(CK_t), .reset(reset),
        .refresh_almost(refresh_almost), .refresh_rdy(refresh_rdy),
        .bank_open(bank_open), .cmd_busy(cmd_busy), .cmd_gnt(cmd_gnt),
        .hold_off(hold_off2), .cmd_req(cmd_req2), .cmd_code(cmd_code2),
        .refresh_busy(refresh_busy2), .clear_refresh(clear_refresh2),
        .ref_count(ref_count2)
    );

    always #5 CK_t = ~CK_t;

    task automatic step();
        @(posedge CK_t);
        #1;
        cyc++;
    endtask

    task automatic zero_inputs();
        refresh_almost = 1'b0;
        refresh_rdy    = 1'b0;
        bank_open      = '0;
        cmd_busy       = 1'b0;
        cmd_gnt        = 1'b0;
    endtask

    task automatic test_reset();
        zero_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n = 0;
        checks++;
        if (outs !== 6'b0 || ref_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state outs=%b cnt=%0d required 0/0", outs, ref_count);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (outs !== 6'b0 || outs2 !== 6'b0 || ref_count !== 16'd0) begin
                errors++;
                $display("FAIL idle_quiet cyc=%0d outs=%b outs2=%b cnt=%0d required 0",
                         cyc, outs, outs2, ref_count);
            end
        end
    endtask

    // Cycle t is the window after posedge t; inputs set in t are sampled at t+1.
    task automatic run_seq(input int lead, input int nbusy, input logic [15:0] banks,
                           input int dp, input int dr, input int drop_rel, input bit noise);
        int a, s, c1, g, c2, r, clr, fin, drop;
        bit pre, pwin, rwin;
        logic [5:0] e;
        logic [1:0] code;
        a   = cyc;
        s   = cyc + lead;
        pre = (banks != 16'd0);
        c1  = s + nbusy + 2;
        g   = c1 + dp;
        c2  = pre ? g + TRP + 1 : c1;
        r   = c2 + dr;
        clr = r + TRFC + 1;
        fin = clr + 1;
        drop = (s + drop_rel < clr) ? s + drop_rel : clr;
        for (int t = a; t <= fin; t++) begin
            pwin = pre && t >= c1 && t <= g;
            rwin = t >= c2 && t <= r;
            refresh_almost = (lead > 0) && t <= drop;
            refresh_rdy    = t >= s && t <= drop;
            cmd_busy       = t > s && t <= s + nbusy;
            bank_open      = (noise && t != s + nbusy + 1) ? 16'($urandom) : banks;
            cmd_gnt        = (pwin && t == g) || (rwin && t == r) ||
                             (noise && !pwin && !rwin && $urandom_range(0, 1) == 1);
            code = pwin ? 2'b01 : (rwin ? 2'b10 : 2'b00);
            e = {((lead > 0) ? t > a : t > s) && t <= clr, pwin || rwin, code,
                 t > s && t <= clr, t == clr};
            checks++;
            if (outs !== e) begin
                errors++;
                $display("FAIL seq_outputs t=%0d got=%b required=%b", t - s, outs, e);
            end
            checks++;
            if (outs2 !== e) begin
                errors++;
                $display("FAIL seq_outputs2 t=%0d got=%b required=%b", t - s, outs2, e);
            end
            checks++;
            if (ref_count !== 16'((t == fin) ? n + 1 : n) ||
                ref_count2 !== 2'((t == fin) ? n + 1 : n)) begin
                errors++;
                $display("FAIL ref_count t=%0d got=%0d/%0d required=%0d", t - s,
                         ref_count, ref_count2, (t == fin) ? n + 1 : n);
            end
            step();
        end
        n++;
        zero_inputs();
    endtask

    task automatic test_almost_then_rdy();
        run_seq(45, 0, 16'h0000, 0, 0, 100, 1'b0);
    endtask

    task automatic test_banks_busy();
        run_seq(0, 3, 16'h0005, 2, 2, 100, 1'b0);
    endtask

    task automatic test_drop_in_wait_rp();
        run_seq(0, 0, 16'h0001, 0, 0, 3, 1'b0);
    endtask

    task automatic test_reset_mid(input int at_rel, input int gnt_rel, input logic [5:0] pre_exp);
        int s;
        s = cyc;
        for (int t = s; t < s + at_rel; t++) begin
            refresh_rdy = (t == s);
            cmd_gnt     = (t == s + gnt_rel);
            step();
        end
        zero_inputs();
        checks++;
        if (outs !== pre_exp) begin
            errors++;
            $display("FAIL reset_mid_pre got=%b required=%b", outs, pre_exp);
        end
        reset   = 1'b1;
        cmd_gnt = 1'b1;
        step();
        reset   = 1'b0;
        cmd_gnt = 1'b0;
        n = 0;
        checks++;
        if (outs !== 6'b0 || ref_count !== 16'd0 || ref_count2 !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid outs=%b cnt=%0d required 0/0", outs, ref_count);
        end
        for (int i = 0; i < 15; i++) begin
            step();
            checks++;
            if (outs !== 6'b0 || ref_count !== 16'd0) begin
                errors++;
                $display("FAIL reset_mid_after cyc=%0d outs=%b cnt=%0d required 0",
                         cyc, outs, ref_count);
            end
        end
    endtask

    task automatic test_wrap();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++)
            run_seq(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                    16'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)), 100, 1'b0);
        checks++;
        if (ref_count2 !== 2'd1 || ref_count !== 16'd5) begin
            errors++;
            $display("FAIL wrap got=%0d/%0d required=1/5", ref_count2, ref_count);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++)
            run_seq(int'($urandom_range(0, 6)), int'($urandom_range(0, 5)),
                    ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'h0000,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 30)), 1'b1);
    endtask

    initial begin
        test_reset();
        test_almost_then_rdy();
        test_banks_busy();
        test_drop_in_wait_rp();
        test_reset_mid(3, -1, 6'b1_1_10_1_0);
        test_reset_mid(6, 2, 6'b1_0_00_1_0);
        test_wrap();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/refresh_sequencer.md
# refresh_sequencer

Controller-side consumer of the refresh interval timer. It turns the timer's `refresh_almost` / `refresh_rdy` indications into an actual refresh sequence on the command path:
- block new activates;
- drain in-flight commands;
- precharge all open banks and wait tRP;
- issue REF and wait tRFC;
- pulse `clear_refresh` to restart the interval.

It sits between the refresh timer and the controller command arbiter, on the DDR clock.

## Interface
- `tRP`, 4: precharge-to-command delay in CK cycles, ≥1.
- `tRFC`, 10: REF-to-command delay in CK cycles, ≥1.
- `BANKS`, 16: number of banks tracked in `bank_open`.
- `CNTW`, 16: width of `ref_count`.

- `CK_t`  in  1  DDR clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `refresh_almost`  in  1  from timer; interval expires soon.
- `refresh_rdy`  in  1  from timer; refresh is due.
- `bank_open`  in  BANKS  bit i = 1 when bank i has an open row.
- `cmd_busy`  in  1  a read/write/activate burst is still in flight.
- `cmd_gnt`  in  1  arbiter accepts the current `cmd_req` this cycle.
- `hold_off`  out  1  arbiter must not issue new ACT while high.
- `cmd_req`  out  1  request to issue `cmd_code`.
- `cmd_code`  out  2  00 none, 01 PREA, 10 REF, 11 reserved (never driven).
- `refresh_busy`  out  1  sequence in progress (any state except IDLE).
- `clear_refresh`  out  1  one-cycle pulse to the timer; restarts the interval.
- `ref_count`  out  CNTW  number of completed refreshes; wraps modulo 2^CNTW.

## Operation
- States: IDLE, DRAIN, PREA, WAIT_RP, REF, WAIT_RFC, CLEAR.
- Outputs are Moore decodes of the registered state, plus a registered `hold_off` flag and the registered `ref_count`.
- IDLE:
  - `refresh_almost` = 1 sets `hold_off`.
  - `refresh_rdy` = 1 sets `hold_off` and moves to DRAIN.
  - If both are high in the same cycle, `refresh_rdy` wins: go to DRAIN.
- DRAIN: stay while `cmd_busy` = 1. When `cmd_busy` = 0, go to PREA if `|bank_open`, else REF.
- PREA: `cmd_req` = 1, `cmd_code` = 01 until `cmd_gnt`. On grant, load the delay counter with tRP−1 and go to WAIT_RP.
- WAIT_RP: decrement each cycle; when the counter is 0, go to REF.
- REF: `cmd_req` = 1, `cmd_code` = 10 until `cmd_gnt`. On grant, load tRFC−1 and go to WAIT_RFC.
- WAIT_RFC: decrement; when 0, go to CLEAR.
- CLEAR: `clear_refresh` = 1 for exactly this cycle, `ref_count` += 1, `hold_off` cleared, go to IDLE.
- Delay counter width is $clog2(max(tRP,tRFC)+1). It is never loaded with a negative value.
- `cmd_gnt` while `cmd_req` = 0 is ignored.
- `refresh_rdy` and `refresh_almost` are sampled only in IDLE. Dropping them mid-sequence does not abort the sequence.
- `bank_open` is sampled only on the DRAIN exit cycle.
- `hold_off` stays high from set through the CLEAR cycle inclusive.
- When `refresh_almost` sets `hold_off` in IDLE and `refresh_rdy` has not yet arrived, `hold_off` stays high until the sequence completes.

## Timing
- Reset values:
  - state IDLE;
  - `hold_off`, `cmd_req`, `refresh_busy`, `clear_refresh` = 0;
  - `cmd_code` = 00;
  - `ref_count` = 0;
  - delay counter = 0.
- Reset asserted mid-sequence, including while `cmd_req` = 1, returns to these values on the next edge. No CLEAR pulse is produced.
- `refresh_rdy` high at edge N in IDLE: DRAIN at N+1 and `refresh_busy` = 1 at N+1.
- DRAIN exit with `cmd_busy` = 0 at edge M: `cmd_req` high from M+1.
- Grant of PREA at edge g:
  - WAIT_RP occupies g+1 … g+tRP;
  - REF `cmd_req` high from g+tRP+1.
- Grant of REF at edge r:
  - WAIT_RFC occupies r+1 … r+tRFC;
  - `clear_refresh` high at r+tRFC+1;
  - IDLE at r+tRFC+2.
- `cmd_req` drops on the cycle after a grant.
- Best case with no open banks and no busy: `refresh_rdy` at N → `cmd_req` (REF) from N+2.
- `ref_count` at 2^CNTW−1 wraps to 0 on the next CLEAR.

## Test plan
- Reset, then idle 20 cycles with all inputs 0 → every output stays 0, `ref_count` = 0.
- `refresh_almost` at cycle 5, `refresh_rdy` at 50, `bank_open` = 0, `cmd_busy` = 0, `cmd_gnt` = 1 whenever requested:
  - `hold_off` high from 6;
  - REF request at 52, granted at 52;
  - `clear_refresh` pulses at 63 (tRFC = 10);
  - `ref_count` = 1;
  - `hold_off` low at 64.
- `bank_open` = 16'h0005, `cmd_busy` high for 3 cycles after `refresh_rdy`, grant delayed 2 cycles each request:
  - PREA issued first;
  - REF request exactly tRP+1 = 5 cycles after the PREA grant;
  - single `clear_refresh` pulse.
- `refresh_rdy` dropped to 0 while in WAIT_RP → sequence completes normally, `clear_refresh` still pulses.
- `reset` asserted during WAIT_RFC → next cycle all outputs at reset values, no `clear_refresh`, `ref_count` unchanged from reset value 0.
- With `CNTW` = 2, run 5 complete sequences → `ref_count` sequence 1, 2, 3, 0, 1.
